// File: rtl/sram_arb_pkg.sv
// Shared types for the IFU/LSU single-port SRAM arbiter: arbitration state,
// response ownership, and byte-lane helpers.
package sram_arb_pkg;

    typedef enum logic {
        LSU_PRI   = 1'b0,
        IFU_FORCE = 1'b1
    } arb_st_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } rsp_own_t;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_LANES   = DEF_DATA_W / BYTE_W;

    function automatic int unsigned lanes_of(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/sram_port_arb.sv
// Per-cycle arbiter sharing one 1-cycle-latency byte-lane SRAM between the IFU
// (read-only) and LSU (read/write) ports, LSU first with IFU starvation relief.
module sram_port_arb
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         ins_e,
    input  logic [ADDR_W-1:0]            ins_a,
    output logic                         ins_gnt,
    output logic                         ins_vld,
    output logic [DATA_W-1:0]            ins,
    input  logic                         dat_re,
    input  logic [lanes_of(DATA_W)-1:0]  dat_we,
    input  logic [ADDR_W-1:0]            dat_a,
    input  logic [DATA_W-1:0]            dat_wd,
    output logic                         dat_gnt,
    output logic                         dat_vld,
    output logic [DATA_W-1:0]            dat_rd,
    output logic                         sram_e,
    output logic [lanes_of(DATA_W)-1:0]  sram_we,
    output logic [ADDR_W-3:0]            sram_a,
    output logic [DATA_W-1:0]            sram_wd,
    input  logic [DATA_W-1:0]            sram_o
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_st_t           state_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic              rsp_vld_q;
    rsp_own_t          rsp_own_q;

    logic lsu_req;
    logic lsu_wr;
    logic rd_gnt;
    logic starve_hit;
    logic addr_lsb_unused;

    assign lsu_wr          = |dat_we;
    assign lsu_req         = dat_re | lsu_wr;
    assign addr_lsb_unused = ^{ins_a[1:0], dat_a[1:0]};

    always_comb begin
        ins_gnt = 1'b0;
        dat_gnt = 1'b0;
        if (rstn) begin
            if (state_q == IFU_FORCE) begin
                ins_gnt = ins_e;
                dat_gnt = lsu_req & ~ins_e;
            end else begin
                dat_gnt = lsu_req;
                ins_gnt = ins_e & ~lsu_req;
            end
        end
    end

    assign sram_e  = ins_gnt | dat_gnt;
    assign sram_we = dat_gnt ? dat_we : {LANES{1'b0}};
    assign sram_wd = dat_gnt ? dat_wd : {DATA_W{1'b0}};
    assign sram_a  = dat_gnt ? dat_a[ADDR_W-1:2] :
                     ins_gnt ? ins_a[ADDR_W-1:2] : {(ADDR_W-2){1'b0}};

    assign rd_gnt = ins_gnt | (dat_gnt & ~lsu_wr);

    // The count never holds STARVE_MAX: the denial that would reach it
    // forces the IFU instead and clears the count in the same edge.
    assign starve_hit = ins_e & ~ins_gnt &
                        (starve_cnt_q >= CNT_W'(STARVE_MAX - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= LSU_PRI;
            starve_cnt_q <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_own_q    <= OWN_IFU;
        end else begin
            rsp_vld_q <= rd_gnt;
            rsp_own_q <= dat_gnt ? OWN_LSU : OWN_IFU;
            state_q   <= starve_hit ? IFU_FORCE : LSU_PRI;
            if (!ins_e || ins_gnt || starve_hit) begin
                starve_cnt_q <= '0;
            end else begin
                starve_cnt_q <= starve_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ins_vld = rsp_vld_q & (rsp_own_q == OWN_IFU);
    assign dat_vld = rsp_vld_q & (rsp_own_q == OWN_LSU);
    assign ins     = ins_vld ? sram_o : {DATA_W{1'b0}};
    assign dat_rd  = dat_vld ? sram_o : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with a behavioural 1-cycle byte-lane SRAM.
module tb_sram_port_arb;
    import sram_arb_pkg::*;

    localparam logic [31:0] W0 = 32'h0A0A_0000;
    localparam logic [31:0] W1 = 32'h0B0B_0001;
    localparam logic [31:0] W2 = 32'h0C0C_0002;
    localparam logic [31:0] W4 = 32'h1122_3344;
    localparam logic [31:0] W5 = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ins_e;
    logic [15:0] ins_a;
    logic        ins_gnt, ins_vld;
    logic [31:0] ins;
    logic        dat_re;
    logic [3:0]  dat_we;
    logic [15:0] dat_a;
    logic [31:0] dat_wd;
    logic        dat_gnt, dat_vld;
    logic [31:0] dat_rd;
    logic        sram_e;
    logic [3:0]  sram_we;
    logic [13:0] sram_a;
    logic [31:0] sram_wd;
    logic [31:0] sram_o = '0;

    logic [31:0] mem [0:255];
    logic        init_done = 1'b0;
    int          wr_cnt5 = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_port_arb #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .ins_e(ins_e), .ins_a(ins_a), .ins_gnt(ins_gnt), .ins_vld(ins_vld), .ins(ins),
        .dat_re(dat_re), .dat_we(dat_we), .dat_a(dat_a), .dat_wd(dat_wd),
        .dat_gnt(dat_gnt), .dat_vld(dat_vld), .dat_rd(dat_rd),
        .sram_e(sram_e), .sram_we(sram_we), .sram_a(sram_a), .sram_wd(sram_wd),
        .sram_o(sram_o)
    );

    always @(posedge clk) begin
        if (!init_done) begin
            mem[0] <= W0; mem[1] <= W1; mem[2] <= W2; mem[4] <= W4; mem[5] <= W5;
            init_done <= 1'b1;
        end else if (sram_e) begin
            if (|sram_we) begin
                for (int l = 0; l < 4; l++)
                    if (sram_we[l]) mem[sram_a[7:0]][8*l +: 8] <= sram_wd[8*l +: 8];
                if (sram_a == 14'd5) wr_cnt5 <= wr_cnt5 + 1;
            end else begin
                sram_o <= mem[sram_a[7:0]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; ins_e = 1'b0; ins_a = '0; dat_re = 1'b0; dat_we = '0; dat_a = '0; dat_wd = '0;
        repeat (2) @(posedge clk);
        #1;
        ins_e = 1'b1; dat_re = 1'b1;
        @(negedge clk);
        total++; if ({ins_gnt, dat_gnt, sram_e} !== 3'b000) begin bad++;
            $display("FAIL reset_grants got=%b want=000", {ins_gnt, dat_gnt, sram_e}); end
        total++; if ({ins_vld, dat_vld} !== 2'b00 || ins !== 32'h0 || dat_rd !== 32'h0) begin bad++;
            $display("FAIL reset_rsp got vld=%b ins=%h rd=%h want 0", {ins_vld, dat_vld}, ins, dat_rd); end
        ins_e = 1'b0; dat_re = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        total++; if (dut.state_q !== LSU_PRI || dut.starve_cnt_q !== 3'd0) begin bad++;
            $display("FAIL reset_state got st=%0d cnt=%0d want 0/0", dut.state_q, dut.starve_cnt_q); end
        $display("reset: released, state and outputs cleared");
        step();
    endtask

    task automatic test_ifu_only();
        logic [31:0] exp_w [3];
        exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2;
        for (int i = 0; i < 3; i++) begin
            ins_e = 1'b1; ins_a = 16'(i * 4);
            @(negedge clk);
            total++; if (ins_gnt !== 1'b1 || sram_a !== 14'(i) || sram_we !== 4'h0) begin bad++;
                $display("FAIL ifu_gnt[%0d] got gnt=%b a=%0d we=%h want 1/%0d/0", i, ins_gnt, sram_a, sram_we, i); end
            if (i > 0) begin
                total++; if (ins_vld !== 1'b1 || ins !== exp_w[i-1] || dat_vld !== 1'b0) begin bad++;
                    $display("FAIL ifu_data[%0d] got vld=%b d=%h dvld=%b want 1/%h/0", i-1, ins_vld, ins, dat_vld, exp_w[i-1]); end
            end
            $display("ifu_only: read addr=%h", ins_a);
            step();
        end
        ins_e = 1'b0;
        @(negedge clk);
        total++; if (ins_vld !== 1'b1 || ins !== W2 || ins_gnt !== 1'b0) begin bad++;
            $display("FAIL ifu_data[2] got vld=%b d=%h gnt=%b want 1/%h/0", ins_vld, ins, ins_gnt, W2); end
        step();
        @(negedge clk);
        total++; if (ins_vld !== 1'b0) begin bad++;
            $display("FAIL ifu_idle got vld=%b want 0", ins_vld); end
        step();
    endtask

    task automatic test_write_readback();
        dat_we = 4'b0011; dat_a = 16'h0010; dat_wd = 32'hAABB_CCDD;
        @(negedge clk);
        total++; if (dat_gnt !== 1'b1 || sram_we !== 4'b0011 || sram_a !== 14'd4 || sram_wd !== 32'hAABB_CCDD) begin bad++;
            $display("FAIL wr_drive got g=%b we=%b a=%0d wd=%h want 1/0011/4/aabbccdd", dat_gnt, sram_we, sram_a, sram_wd); end
        $display("write: addr=0010 we=0011 wd=aabbccdd");
        step();
        dat_we = 4'b0000; dat_re = 1'b1; dat_a = 16'h0012;
        @(negedge clk);
        total++; if (dat_vld !== 1'b0 || dat_gnt !== 1'b1 || sram_we !== 4'h0 || sram_a !== 14'd4) begin bad++;
            $display("FAIL wr_novld got vld=%b g=%b we=%h a=%0d want 0/1/0/4", dat_vld, dat_gnt, sram_we, sram_a); end
        step();
        dat_re = 1'b0;
        @(negedge clk);
        total++; if (dat_vld !== 1'b1 || dat_rd !== 32'h1122_CCDD || ins_vld !== 1'b0 || ins !== 32'h0) begin bad++;
            $display("FAIL rd_back got vld=%b rd=%h ivld=%b ins=%h want 1/1122ccdd/0/0", dat_vld, dat_rd, ins_vld, ins); end
        $display("read: addr=0010 data=%h", dat_rd);
        step();
    endtask

    task automatic test_starve();
        logic lsu_win, prev_lsu;
        prev_lsu = 1'b0;
        ins_a = 16'h0008; dat_a = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            ins_e = 1'b1; dat_re = 1'b1;
            lsu_win = (k % 5) != 4;
            @(negedge clk);
            total++; if (dat_gnt !== lsu_win || ins_gnt !== !lsu_win) begin bad++;
                $display("FAIL starve_gnt[%0d] got d=%b i=%b want d=%b", k, dat_gnt, ins_gnt, lsu_win); end
            if (k > 0) begin
                total++; if (dat_vld !== prev_lsu || ins_vld !== !prev_lsu ||
                             dat_rd !== (prev_lsu ? W0 : 32'h0) || ins !== (prev_lsu ? 32'h0 : W2)) begin bad++;
                    $display("FAIL starve_rsp[%0d] got dv=%b iv=%b rd=%h ins=%h", k, dat_vld, ins_vld, dat_rd, ins); end
            end
            $display("starve: cycle %0d winner=%s", k, lsu_win ? "LSU" : "IFU");
            prev_lsu = lsu_win;
            step();
        end
        ins_e = 1'b0; dat_re = 1'b0;
        @(negedge clk);
        total++; if (ins_vld !== 1'b1 || ins !== W2 || dat_vld !== 1'b0) begin bad++;
            $display("FAIL starve_last got iv=%b ins=%h dv=%b want 1/%h/0", ins_vld, ins, dat_vld, W2); end
        step();
    endtask

    task automatic test_no_force();
        ins_a = 16'h0000; dat_a = 16'h0000; dat_re = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ins_e = 1'b1;
            step();
        end
        ins_e = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            ins_e = 1'b1;
            @(negedge clk);
            if (k == 0) begin
                total++; if (dut.starve_cnt_q !== 3'd0 || dut.state_q !== LSU_PRI) begin bad++;
                    $display("FAIL noforce_clr got cnt=%0d st=%0d want 0/0", dut.starve_cnt_q, dut.state_q); end
            end
            total++; if (ins_gnt !== (k == 4) || dat_gnt !== (k != 4)) begin bad++;
                $display("FAIL noforce_gnt[%0d] got i=%b d=%b", k, ins_gnt, dat_gnt); end
            step();
        end
        $display("no_force: counter cleared on ins_e drop");
        ins_e = 1'b0; dat_re = 1'b0;
        step();
    endtask

    task automatic test_force_write();
        ins_a = 16'h0000; dat_a = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            ins_e = 1'b1; dat_re = 1'b1;
            step();
        end
        dat_re = 1'b0; dat_we = 4'b1100; dat_a = 16'h0014; dat_wd = 32'hCAFE_F00D;
        @(negedge clk);
        total++; if (dut.state_q !== IFU_FORCE || ins_gnt !== 1'b1 || dat_gnt !== 1'b0 || sram_we !== 4'h0) begin bad++;
            $display("FAIL force_ifu got st=%0d i=%b d=%b we=%h want 1/1/0/0", dut.state_q, ins_gnt, dat_gnt, sram_we); end
        step();
        ins_e = 1'b0;
        @(negedge clk);
        total++; if (dat_gnt !== 1'b1 || sram_we !== 4'b1100 || sram_a !== 14'd5 || ins_vld !== 1'b1 || ins !== W0) begin bad++;
            $display("FAIL force_wr got d=%b we=%b a=%0d iv=%b ins=%h", dat_gnt, sram_we, sram_a, ins_vld, ins); end
        $display("force_write: write addr=0014 granted after IFU");
        step();
        dat_we = 4'b0000; dat_re = 1'b1;
        step();
        dat_re = 1'b0;
        @(negedge clk);
        total++; if (dat_vld !== 1'b1 || dat_rd !== 32'hCAFE_5678 || wr_cnt5 !== 1) begin bad++;
            $display("FAIL force_mem got vld=%b rd=%h writes=%0d want 1/cafe5678/1", dat_vld, dat_rd, wr_cnt5); end
        step();
    endtask

    task automatic test_reset_mid();
        ins_e = 1'b1; dat_re = 1'b1; ins_a = 16'h0000; dat_a = 16'h0014;
        step();
        @(negedge clk);
        total++; if (dat_gnt !== 1'b1 || dat_vld !== 1'b1 || dat_rd !== 32'hCAFE_5678) begin bad++;
            $display("FAIL mid_pre got g=%b vld=%b rd=%h want 1/1/cafe5678", dat_gnt, dat_vld, dat_rd); end
        step();
        rstn = 1'b0;
        #1;
        total++; if ({ins_vld, dat_vld} !== 2'b00 || dat_rd !== 32'h0 || {ins_gnt, dat_gnt, sram_e} !== 3'b000) begin bad++;
            $display("FAIL mid_rst got vld=%b rd=%h g=%b", {ins_vld, dat_vld}, dat_rd, {ins_gnt, dat_gnt, sram_e}); end
        total++; if (dut.state_q !== LSU_PRI || dut.starve_cnt_q !== 3'd0) begin bad++;
            $display("FAIL mid_state got st=%0d cnt=%0d want 0/0", dut.state_q, dut.starve_cnt_q); end
        ins_e = 1'b0; dat_re = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        total++; if ({ins_vld, dat_vld} !== 2'b00) begin bad++;
            $display("FAIL mid_post got vld=%b want 00", {ins_vld, dat_vld}); end
        $display("reset_mid: in-flight response dropped");
        step();
    endtask

    initial begin
        test_reset();
        test_ifu_only();
        test_write_readback();
        test_starve();
        test_no_force();
        test_force_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
